// File: rtl/cpu_result_monitor.sv
// Watches the CPU's terminal/answer pair, debounces terminal, latches the final answer,
// counts run cycles and reports pass/fail/timeout for LEDs and the simulation bench.
module cpu_result_monitor #(
  parameter logic [7:0]  EXPECTED    = 8'h00,
  parameter int unsigned TERM_STABLE = 4,
  parameter int unsigned TIMEOUT     = 1_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             terminal_i,
  input  logic [7:0]       answer_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [7:0]       result_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  // stab never holds more than TERM_STABLE-1: the edge that would reach TERM_STABLE accepts.
  localparam int unsigned      StabW    = (TERM_STABLE > 1) ? $clog2(TERM_STABLE) : 1;
  localparam logic [StabW-1:0] StabOne  = StabW'(1);
  localparam logic [StabW-1:0] StabLast = StabW'(TERM_STABLE - 1);
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(TIMEOUT - 1);
  localparam bit               Instant  = (TERM_STABLE == 1);

  typedef enum logic [1:0] {StRun, StConfirm, StDone, StTimeout} state_e;

  state_e           state_q;
  logic [StabW-1:0] stab_q;
  logic [7:0]       held_q;
  logic [7:0]       result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, pass_q, fail_q, timeout_q;

  logic running, accept, expire;

  always_comb begin
    running = (state_q == StRun) || (state_q == StConfirm);
    accept  = 1'b0;
    if (terminal_i) begin
      if (state_q == StRun) begin
        accept = Instant;
      end else if (state_q == StConfirm) begin
        accept = (answer_i == held_q) && (stab_q == StabLast);
      end
    end
    // Acceptance on the final counted edge beats the timeout.
    expire = running && (cnt_q == CntLast) && !accept;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StRun;
      stab_q    <= '0;
      held_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (terminal_i) begin
            held_q  <= answer_i;
            stab_q  <= StabOne;
            state_q <= StConfirm;
          end
        end
        StConfirm: begin
          if (!terminal_i) begin
            stab_q  <= '0;
            state_q <= StRun;
          end else if (answer_i != held_q) begin
            held_q <= answer_i;
            stab_q <= StabOne;
          end else if (!accept) begin
            stab_q <= stab_q + StabOne;
          end
        end
        StDone, StTimeout: ;
      endcase

      if (running) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // These override the state chosen above on the deciding edge.
      if (accept) begin
        state_q  <= StDone;
        result_q <= answer_i;
        done_q   <= 1'b1;
        pass_q   <= (answer_i == EXPECTED);
        fail_q   <= (answer_i != EXPECTED);
      end else if (expire) begin
        state_q   <= StTimeout;
        timeout_q <= 1'b1;
        fail_q    <= 1'b1;
      end
    end
  end

  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign timeout_o     = timeout_q;
  assign result_o      = result_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_result_monitor.sv
// Bench for cpu_result_monitor: three parameterisations share one stimulus stream and are
// checked against a history-window reference model, a directed table and corner sequences.
module tb_cpu_result_monitor;

  localparam int unsigned CntW = 16;
  localparam int unsigned To   = 100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic terminal = 1'b0;
  logic [7:0] answer = 8'h00;

  logic [2:0] done_w, pass_w, fail_w, to_w;
  logic [7:0] res_w [3];
  logic [CntW-1:0] cnt_w [3];

  always #5 clk = ~clk;

  cpu_result_monitor #(.EXPECTED(8'h00), .TERM_STABLE(4), .TIMEOUT(To), .CNT_W(CntW)) u_a (
    .clk_i(clk), .rstn_i(rstn), .terminal_i(terminal), .answer_i(answer),
    .done_o(done_w[0]), .pass_o(pass_w[0]), .fail_o(fail_w[0]), .timeout_o(to_w[0]),
    .result_o(res_w[0]), .cycle_count_o(cnt_w[0])
  );
  cpu_result_monitor #(.EXPECTED(8'h37), .TERM_STABLE(4), .TIMEOUT(To), .CNT_W(CntW)) u_b (
    .clk_i(clk), .rstn_i(rstn), .terminal_i(terminal), .answer_i(answer),
    .done_o(done_w[1]), .pass_o(pass_w[1]), .fail_o(fail_w[1]), .timeout_o(to_w[1]),
    .result_o(res_w[1]), .cycle_count_o(cnt_w[1])
  );
  cpu_result_monitor #(.EXPECTED(8'h00), .TERM_STABLE(1), .TIMEOUT(To), .CNT_W(CntW)) u_c (
    .clk_i(clk), .rstn_i(rstn), .terminal_i(terminal), .answer_i(answer),
    .done_o(done_w[2]), .pass_o(pass_w[2]), .fail_o(fail_w[2]), .timeout_o(to_w[2]),
    .result_o(res_w[2]), .cycle_count_o(cnt_w[2])
  );

  int errors = 0;
  int checks = 0;

  // Reference model: keep recent samples; a run is accepted on the first edge whose last
  // TERM_STABLE samples all have terminal=1 and an identical answer.
  int         m_ts  [3] = '{4, 4, 1};
  logic [7:0] m_exp [3] = '{8'h00, 8'h37, 8'h00};
  logic [8:0] hist [$];
  bit         m_done [3];
  bit         m_to   [3];
  logic [7:0] m_res  [3];
  int         m_cnt  [3];

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0; m_to[i] = 0; m_res[i] = 8'h00; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic t, input logic [7:0] a);
    hist.push_back({t, a});
    if (hist.size() > 8) void'(hist.pop_front());
    for (int i = 0; i < 3; i++) begin
      if (!m_done[i] && !m_to[i]) begin
        bit ok;
        m_cnt[i]++;
        ok = (hist.size() >= m_ts[i]);
        for (int k = 0; k < m_ts[i] && ok; k++) begin
          logic [8:0] s;
          s = hist[hist.size() - 1 - k];
          if (!s[8] || s[7:0] != a) ok = 0;
        end
        if (ok) begin
          m_done[i] = 1; m_res[i] = a;
        end else if (m_cnt[i] == To) begin
          m_to[i] = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      bit mp, mf;
      mp = m_done[i] && (m_res[i] == m_exp[i]);
      mf = (m_done[i] && (m_res[i] != m_exp[i])) || m_to[i];
      chk($sformatf("done[%0d]", i), done_w[i], m_done[i]);
      chk($sformatf("pass[%0d]", i), pass_w[i], mp);
      chk($sformatf("fail[%0d]", i), fail_w[i], mf);
      chk($sformatf("timeout[%0d]", i), to_w[i], m_to[i]);
      chk($sformatf("result[%0d]", i), res_w[i], m_res[i]);
      chk($sformatf("cycles[%0d]", i), cnt_w[i], m_cnt[i]);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic [7:0] a);
    @(negedge clk);
    rstn = ~r; terminal = t; answer = a;
    if (r) begin
      #1 model_reset();
    end else begin
      @(posedge clk);
      model_edge(t, a);
      #1;
    end
    compare_all();
  endtask

  // Assert reset away from any clock edge; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 model_reset();
    chk({tag, "_done"}, done_w[0], 0);
    chk({tag, "_fail"}, fail_w[1], 0);
    chk({tag, "_cycles"}, cnt_w[0], 0);
    compare_all();
  endtask

  typedef struct {
    logic r; logic t; logic [7:0] a;
    logic d; logic p; logic [7:0] res; int cnt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl = '{
      '{1, 0, 8'h00, 0, 0, 8'h00, 0},
      '{0, 1, 8'h33, 0, 0, 8'h00, 1},
      '{0, 1, 8'h33, 0, 0, 8'h00, 2},
      '{0, 0, 8'h33, 0, 0, 8'h00, 3},
      '{0, 1, 8'h33, 0, 0, 8'h00, 4},
      '{0, 1, 8'h33, 0, 0, 8'h00, 5},
      '{0, 1, 8'h33, 0, 0, 8'h00, 6},
      '{0, 1, 8'h33, 1, 0, 8'h33, 7},
      '{0, 0, 8'h00, 1, 0, 8'h33, 7},
      '{1, 0, 8'h00, 0, 0, 8'h00, 0},
      '{0, 1, 8'h11, 0, 0, 8'h00, 1},
      '{0, 1, 8'h11, 0, 0, 8'h00, 2},
      '{0, 1, 8'h22, 0, 0, 8'h00, 3},
      '{0, 1, 8'h22, 0, 0, 8'h00, 4},
      '{0, 1, 8'h22, 0, 0, 8'h00, 5},
      '{0, 1, 8'h22, 1, 0, 8'h22, 6},
      '{0, 1, 8'h00, 1, 0, 8'h22, 6},
      '{1, 0, 8'h00, 0, 0, 8'h00, 0}
    };
    model_reset();

    // Directed table against instance A (EXPECTED=00, TERM_STABLE=4).
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].a);
      chk($sformatf("tbl%0d_done", i), done_w[0], tbl[i].d);
      chk($sformatf("tbl%0d_pass", i), pass_w[0], tbl[i].p);
      chk($sformatf("tbl%0d_fail", i), fail_w[0], tbl[i].d && !tbl[i].p);
      chk($sformatf("tbl%0d_result", i), res_w[0], tbl[i].res);
      chk($sformatf("tbl%0d_cycles", i), cnt_w[0], tbl[i].cnt);
    end

    // Terminal=1, answer=00 sampled from edge 10; accepted on edge 13.
    step(1, 0, 8'h00);
    for (int i = 1; i <= 9; i++) step(0, 0, 8'h00);
    for (int i = 10; i <= 12; i++) step(0, 1, 8'h00);
    chk("c1_early_done", done_w[0], 0);
    chk("c1_ts1_done", done_w[2], 1);
    chk("c1_ts1_cycles", cnt_w[2], 10);
    step(0, 1, 8'h00);
    chk("c1_done", done_w[0], 1);
    chk("c1_pass", pass_w[0], 1);
    chk("c1_fail", fail_w[0], 0);
    chk("c1_cycles", cnt_w[0], 13);
    chk("c1_b_fail", fail_w[1], 1);

    // Wrong answer 5A against EXPECTED=37.
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h5A);
    chk("c2_done", done_w[1], 1);
    chk("c2_pass", pass_w[1], 0);
    chk("c2_fail", fail_w[1], 1);
    chk("c2_result", res_w[1], 8'h5A);

    // Timeout after exactly 100 edges; counter then frozen.
    step(1, 0, 8'h00);
    for (int i = 0; i < 99; i++) step(0, 0, 8'h00);
    chk("c5_pre_timeout", to_w[0], 0);
    step(0, 0, 8'h00);
    chk("c5_timeout", to_w[0], 1);
    chk("c5_fail", fail_w[0], 1);
    chk("c5_done", done_w[0], 0);
    chk("c5_cycles", cnt_w[0], 100);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
    chk("c5_frozen", cnt_w[0], 100);
    chk("c5_no_done", done_w[0], 0);

    // Timeout edge coinciding with acceptance: acceptance wins.
    step(1, 0, 8'h00);
    for (int i = 0; i < 96; i++) step(0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h37);
    chk("race_done", done_w[1], 1);
    chk("race_pass", pass_w[1], 1);
    chk("race_timeout", to_w[1], 0);
    chk("race_cycles", cnt_w[1], 100);

    // Reset pulsed in CONFIRM and in DONE, then a clean run.
    step(1, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    async_reset("c6a");
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    chk("c6_done_before", done_w[0], 1);
    async_reset("c6b");
    chk("c6b_pass", pass_w[0], 0);
    for (int i = 1; i <= 9; i++) step(0, 0, 8'h00);
    for (int i = 10; i <= 13; i++) step(0, 1, 8'h00);
    chk("c6_rerun_done", done_w[0], 1);
    chk("c6_rerun_cycles", cnt_w[0], 13);

    // Randomised traffic against the model.
    step(1, 0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      logic r, t;
      logic [7:0] a;
      r = ($urandom_range(0, 149) == 0);
      t = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'h37;
        2:       a = answer;
        default: a = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 4) != 0) a = answer;
      step(r, t, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
